// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared width codes, FSM states and lane helpers for dmem_responder
package dmem_pkg;

  localparam logic [1:0] WIDTH_WORD = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_BYTE = 2'b10;
  localparam logic [1:0] WIDTH_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RMW_WAIT,
    DONE
  } state_t;

  // Pull the addressed byte/half out of a fetched word and extend it to 32 bits.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [1:0]  width,
                                               input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (width)
      WIDTH_HALF: r = {{16{sgn & h[15]}}, h};
      WIDTH_BYTE: r = {{24{sgn & b[7]}}, b};
      default:    r = word;
    endcase
    return r;
  endfunction

  // Drop the low byte/half of the store data into the addressed lane; other lanes keep the fetched value.
  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [31:0] data,
                                             input logic [1:0]  off,
                                             input logic [1:0]  width);
    logic [31:0] r;
    r = word;
    case (width)
      WIDTH_BYTE: begin
        case (off)
          2'd0:    r[7:0]   = data[7:0];
          2'd1:    r[15:8]  = data[7:0];
          2'd2:    r[23:16] = data[7:0];
          default: r[31:24] = data[7:0];
        endcase
      end
      WIDTH_HALF: begin
        if (off[1]) r[31:16] = data[15:0];
        else        r[15:0]  = data[15:0];
      end
      default: r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sp_ram_sync.sv
// rtl/sp_ram_sync.sv - single-port synchronous word RAM, registered read, read-before-write
module sp_ram_sync #(
  parameter int DEPTH_WORDS = 2048,
  parameter int ADDR_W      = 11
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Read the old contents every cycle; a write in the same cycle lands after the read.
  always_ff @(posedge clk) begin
    rdata <= mem[addr];
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - CPU data-memory responder over a synchronous word RAM
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 2048,
  parameter int ADDR_W      = 11
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        dmem_r,
  input  logic        dmem_w,
  input  logic [1:0]  dmem_width,
  input  logic        dmem_sign,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_in,
  output logic [31:0] dmem_out,
  output logic        ready,
  output logic        err
);

  state_t             state_q, state_d;
  logic [ADDR_W+1:0]  addr_q;
  logic [1:0]         width_q;
  logic               sign_q;
  logic [31:0]        data_q;
  logic               err_q;

  logic               req;
  logic               fault;
  logic               ram_we_raw;
  logic               ram_we;
  logic [ADDR_W-1:0]  ram_addr;
  logic [31:0]        ram_wdata;
  logic [31:0]        ram_rdata;

  assign req = dmem_r | dmem_w;

  // Decode every reason a request cannot touch the RAM.
  always_comb begin
    fault = 1'b0;
    if (dmem_r && dmem_w)                                   fault = 1'b1;
    if (dmem_width == WIDTH_ILL)                            fault = 1'b1;
    if (dmem_width == WIDTH_HALF && dmem_addr[0])           fault = 1'b1;
    if (dmem_width == WIDTH_WORD && dmem_addr[1:0] != 2'b00) fault = 1'b1;
    if ({2'b00, dmem_addr[31:2]} >= 32'(DEPTH_WORDS))       fault = 1'b1;
  end

  // State register; reset aborts whatever was in flight.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state and RAM command; IDLE drives the RAM straight from the request, later states from the captured copy.
  always_comb begin
    state_d    = state_q;
    ram_we_raw = 1'b0;
    ram_addr   = addr_q[ADDR_W+1:2];
    ram_wdata  = lane_merge(ram_rdata, data_q, addr_q[1:0], width_q);
    case (state_q)
      IDLE: begin
        ram_addr  = dmem_addr[ADDR_W+1:2];
        ram_wdata = dmem_in;
        if (req) begin
          if (fault) begin
            state_d = DONE;
          end else if (dmem_w && dmem_width == WIDTH_WORD) begin
            ram_we_raw = 1'b1;
            state_d    = DONE;
          end else if (dmem_r) begin
            state_d = RD_WAIT;
          end else begin
            state_d = RMW_WAIT;
          end
        end
      end
      RD_WAIT: state_d = DONE;
      RMW_WAIT: begin
        ram_we_raw = 1'b1;
        state_d    = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset is asynchronous, so the write enable must also be masked by it directly.
  assign ram_we = ram_we_raw & rst;

  // Capture the request at acceptance and produce read data once the RAM word arrives.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      addr_q   <= '0;
      width_q  <= WIDTH_WORD;
      sign_q   <= 1'b0;
      data_q   <= '0;
      err_q    <= 1'b0;
      dmem_out <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            addr_q  <= dmem_addr[ADDR_W+1:0];
            width_q <= dmem_width;
            sign_q  <= dmem_sign;
            data_q  <= dmem_in;
            err_q   <= fault;
            if (fault) dmem_out <= '0;
          end
        end
        RD_WAIT: dmem_out <= lane_extract(ram_rdata, addr_q[1:0], width_q, sign_q);
        default: ;
      endcase
    end
  end

  assign ready = (state_q == DONE);
  assign err   = ready & err_q;

  sp_ram_sync #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_W     (ADDR_W)
  ) u_ram (
    .clk  (clk_in),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

endmodule
